stopwatch_top: RTL and testbench

STOPWATCH_TOP -- requirements
Module: stopwatch_top

---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/tick_gen.sv | 27 ++
 rtl/stopwatch_top.sv | 29 ++
 tb/tb_stopwatch_top.sv | 115 +++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared defaults and sizing helper for the stopwatch block.
package stopwatch_pkg;

   localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
   localparam int unsigned SEC_W_DEFAULT  = 13;

   // Bits needed to hold prescaler values 0..hz-1; never narrower than one bit.
   function automatic int presc_width(input longint unsigned hz);
      return (hz < 2) ? 1 : $clog2(hz);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler that counts CLK_HZ clk cycles and flags the last cycle of each second.
module tick_gen
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int              PW   = presc_width(64'(CLK_HZ));
   localparam logic [PW-1:0]   TERM = PW'(CLK_HZ - 1);

   logic [PW-1:0] count;

   // Tick is decoded from the counter register alone, so it is stable for the whole cycle.
   assign tick = (count == TERM);

   // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)       count <= '0;
      else if (tick) count <= '0;
      else           count <= count + PW'(1);
   end

endmodule

// File: rtl/stopwatch_top.sv
// Elapsed-seconds counter driven by the tick_gen prescaler.
module stopwatch_top
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
   parameter int unsigned SEC_W  = SEC_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   output logic [SEC_W-1:0] seconds
);

   logic tick;

   tick_gen #(
      .CLK_HZ(CLK_HZ)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Reset wins over a coincident tick; the counter wraps naturally at 2^SEC_W.
   always_ff @(posedge clk) begin
      if (rst)       seconds <= '0;
      else if (tick) seconds <= seconds + SEC_W'(1);
   end

endmodule

// File: tb/tb_stopwatch_top.sv
// Directed bench for stopwatch_top: timing, mid-second and on-tick reset, wrap, minimum CLK_HZ.
module tb_stopwatch_top;

   logic        clk = 1'b0;
   logic        rst_a = 1'b1;
   logic        rst_b = 1'b1;
   logic [12:0] sec_a;
   logic [2:0]  sec_b;
   logic [3:0]  sec_c;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stopwatch_top #(.CLK_HZ(10), .SEC_W(13)) dut_a (.clk(clk), .rst(rst_a), .seconds(sec_a));
   stopwatch_top #(.CLK_HZ(10), .SEC_W(3))  dut_b (.clk(clk), .rst(rst_b), .seconds(sec_b));
   stopwatch_top #(.CLK_HZ(2),  .SEC_W(4))  dut_c (.clk(clk), .rst(rst_b), .seconds(sec_c));

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_a(input int n);
      rst_a = 1'b1;
      edges(n);
      rst_a = 1'b0;
   endtask

   initial begin
      // Release after 3 reset cycles; first increment on edge 10, second on edge 20.
      reset_a(3);
      check("a_reset_state", 32'(sec_a), 0);
      for (int i = 1; i <= 9; i++) begin
         edges(1);
         check($sformatf("a_pre_first_edge%0d", i), 32'(sec_a), 0);
      end
      edges(1);
      check("a_edge10", 32'(sec_a), 1);
      edges(9);
      check("a_edge19", 32'(sec_a), 1);
      edges(1);
      check("a_edge20", 32'(sec_a), 2);

      // Free run up to 20 seconds, each change exactly 10 cycles apart.
      for (int k = 3; k <= 20; k++) begin
         edges(9);
         check($sformatf("a_hold_before_%0d", k), 32'(sec_a), 32'(k - 1));
         edges(1);
         check($sformatf("a_step_to_%0d", k), 32'(sec_a), 32'(k));
      end

      // One-cycle reset at post-release cycle 15 discards the partial second.
      reset_a(3);
      edges(15);
      check("a_mid_before_rst", 32'(sec_a), 1);
      rst_a = 1'b1;
      edges(1);
      rst_a = 1'b0;
      check("a_mid_after_rst", 32'(sec_a), 0);
      edges(9);
      check("a_mid_edge9", 32'(sec_a), 0);
      edges(1);
      check("a_mid_edge10", 32'(sec_a), 1);

      // Reset on the exact tick edge: no increment, next one at cycle 20.
      reset_a(3);
      edges(9);
      check("a_tick_edge9", 32'(sec_a), 0);
      rst_a = 1'b1;
      edges(1);
      rst_a = 1'b0;
      check("a_tick_edge10_rst", 32'(sec_a), 0);
      edges(9);
      check("a_tick_edge19", 32'(sec_a), 0);
      edges(1);
      check("a_tick_edge20", 32'(sec_a), 1);

      // SEC_W = 3 wraps after 7; CLK_HZ = 2 ticks every other edge.
      rst_b = 1'b1;
      edges(2);
      rst_b = 1'b0;
      check("b_reset_state", 32'(sec_b), 0);
      check("c_reset_state", 32'(sec_c), 0);
      edges(1);
      check("c_edge1", 32'(sec_c), 0);
      edges(1);
      check("c_edge2", 32'(sec_c), 1);
      edges(2);
      check("c_edge4", 32'(sec_c), 2);
      edges(66);
      check("b_tick7", 32'(sec_b), 7);
      check("c_edge70", 32'(sec_c), 3);
      edges(9);
      check("b_before_wrap", 32'(sec_b), 7);
      edges(1);
      check("b_wrap_tick8", 32'(sec_b), 0);
      edges(10);
      check("b_tick9", 32'(sec_b), 1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
